// File: rtl/pipelined_addsub_n.sv
// rtl/pipelined_addsub_n.sv - parametrised pipelined add/subtract unit with valid/ready handshake
module pipelined_addsub_n #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             C,
  output logic             V
);

  localparam int SEG = WIDTH / STAGES;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_addsub_n: STAGES must divide WIDTH and lie in 1..WIDTH");
  end

  // xs_q[k] is a rotating skew register: unused X segments sit at the bottom and
  // finished result segments are inserted at the top, so after the last stage it
  // holds the complete sum. ye_q[k] carries the not-yet-used effective Y segments.
  logic [STAGES-1:0] vld_q, vld_d;
  logic [WIDTH-1:0]  xs_q  [STAGES];
  logic [WIDTH-1:0]  xs_d  [STAGES];
  logic [WIDTH-1:0]  ye_q  [STAGES];
  logic [WIDTH-1:0]  ye_d  [STAGES];
  logic              cy_q  [STAGES];
  logic              cy_d  [STAGES];
  logic              sub_q [STAGES];
  logic              sub_d [STAGES];
  logic              v_q   [STAGES];
  logic              v_d   [STAGES];

  // Per-stage operands: stage 0 takes the inputs, stage k takes stage k-1's registers
  logic [WIDTH-1:0]  xs_src  [STAGES];
  logic [WIDTH-1:0]  ye_src  [STAGES];
  logic              cy_src  [STAGES];
  logic              sub_src [STAGES];
  logic [SEG:0]      seg_sum [STAGES];

  logic advance;

  assign out_valid = vld_q[STAGES-1];
  assign advance   = ~out_valid | out_ready;
  assign in_ready  = advance;
  assign Sum       = xs_q[STAGES-1];
  assign C         = cy_q[STAGES-1];
  assign V         = v_q[STAGES-1];

  // Segment adders: each stage adds its SEG-bit slice with the carry from the stage before
  always_comb begin
    xs_src[0]  = X;
    ye_src[0]  = sub ? ~Y : Y;
    cy_src[0]  = cin ^ sub;
    sub_src[0] = sub;
    vld_d[0]   = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      xs_src[k]  = xs_q[k-1];
      ye_src[k]  = ye_q[k-1];
      cy_src[k]  = cy_q[k-1];
      sub_src[k] = sub_q[k-1];
      vld_d[k]   = vld_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      seg_sum[k] = {1'b0, xs_src[k][SEG-1:0]} + {1'b0, ye_src[k][SEG-1:0]}
                 + (SEG+1)'(cy_src[k]);
      xs_d[k]    = (xs_src[k] >> SEG) | (WIDTH'(seg_sum[k][SEG-1:0]) << (WIDTH - SEG));
      ye_d[k]    = ye_src[k] >> SEG;
      sub_d[k]   = sub_src[k];
      if (k == STAGES - 1) begin
        // Top segment: carry becomes borrow for subtract; overflow from the sign bits
        cy_d[k] = seg_sum[k][SEG] ^ sub_src[k];
        v_d[k]  = (xs_src[k][SEG-1] == ye_src[k][SEG-1])
                & (seg_sum[k][SEG-1] != xs_src[k][SEG-1]);
      end else begin
        cy_d[k] = seg_sum[k][SEG];
        v_d[k]  = 1'b0;
      end
    end
  end

  // Whole pipeline steps together on advance; data only loads behind a valid token
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        xs_q[k]  <= '0;
        ye_q[k]  <= '0;
        cy_q[k]  <= 1'b0;
        sub_q[k] <= 1'b0;
        v_q[k]   <= 1'b0;
      end
    end else if (advance) begin
      vld_q <= vld_d;
      for (int k = 0; k < STAGES; k++) begin
        if (vld_d[k]) begin
          xs_q[k]  <= xs_d[k];
          ye_q[k]  <= ye_d[k];
          cy_q[k]  <= cy_d[k];
          sub_q[k] <= sub_d[k];
          v_q[k]   <= v_d[k];
        end
      end
    end
  end

endmodule
